// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch path: controller states, field width and
// the packed lap record {min, sec, cs}.
package stopwatch_pkg;

  localparam int FIELD_W = 7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STOP   = 2'd2,
    S_REVIEW = 2'd3
  } state_t;

  typedef struct packed {
    logic [FIELD_W-1:0] min;
    logic [FIELD_W-1:0] sec;
    logic [FIELD_W-1:0] cs;
  } lap_t;

endpackage

// File: rtl/sw_time_counter.sv
// Cascaded centisecond / second / minute counter. Advances once per enabled
// cycle, synchronous clear has priority, and wrap pulses for one cycle when
// the full terminal count rolls back to zero.
module sw_time_counter
  import stopwatch_pkg::*;
#(
  parameter int CS_MAX  = 99,
  parameter int SEC_MAX = 59,
  parameter int MIN_MAX = 59
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  output logic [FIELD_W-1:0] cs,
  output logic [FIELD_W-1:0] sec,
  output logic [FIELD_W-1:0] min,
  output logic               wrap
);

  localparam logic [FIELD_W-1:0] CS_T  = FIELD_W'(CS_MAX);
  localparam logic [FIELD_W-1:0] SEC_T = FIELD_W'(SEC_MAX);
  localparam logic [FIELD_W-1:0] MIN_T = FIELD_W'(MIN_MAX);

  // Counter cascade; wrap is registered so it lines up with the zeroed time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs   <= '0;
      sec  <= '0;
      min  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr) begin
        cs  <= '0;
        sec <= '0;
        min <= '0;
      end else if (en) begin
        if (cs == CS_T) begin
          cs <= '0;
          if (sec == SEC_T) begin
            sec <= '0;
            if (min == MIN_T) begin
              min  <= '0;
              wrap <= 1'b1;
            end else begin
              min <= min + 1'b1;
            end
          end else begin
            sec <= sec + 1'b1;
          end
        end else begin
          cs <= cs + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch run/stop/lap/clear/review sequencer with lap buffer and display
// select. Buttons are registered, then rising-edge detected, so an action
// shows on the outputs two clocks after the raw level rises. Same-cycle edge
// priority is clr > ss > lap > rev.
// Build option: define STOPWATCH_LAP_OVERWRITE_EN to make the lap buffer a
// ring that overwrites the oldest slot; otherwise laps are ignored when full.
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int N_LAPS  = 5,
  parameter int CS_MAX  = 99,
  parameter int SEC_MAX = 59,
  parameter int MIN_MAX = 59
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               tick_cs,
  input  logic               btn_ss,
  input  logic               btn_lap,
  input  logic               btn_clr,
  input  logic               btn_rev,
  output logic               running,
  output logic [FIELD_W-1:0] disp_min,
  output logic [FIELD_W-1:0] disp_sec,
  output logic [FIELD_W-1:0] disp_cs,
  output logic [2:0]         disp_slot,
  output logic [2:0]         lap_count,
  output logic [5:0]         slot_led,
  output logic               wrap,
  output logic [1:0]         state_dbg
);

  localparam logic [2:0] NL   = 3'(N_LAPS);
  localparam logic [2:0] LAST = 3'(N_LAPS - 1);

  // Button bit order everywhere: {clr, ss, lap, rev}.
  logic [3:0] btn_r;
  logic [3:0] btn_q;
  logic [3:0] btn_edge;
  logic       clr_e, ss_e, lap_e, rev_e;

  state_t     state, state_d;
  lap_t       laps [N_LAPS];
  lap_t       live;
  lap_t       shown;
  logic [2:0] wr_ptr, rd_ptr;
  logic [2:0] wr_next, oldest;
  logic       lap_full, lap_ok;
  logic       clear_all, do_lap, rev_enter, rev_step;
  logic       cnt_en;

  // Register button levels, then keep a delayed copy for edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      btn_r <= '0;
      btn_q <= '0;
    end else begin
      btn_r <= {btn_clr, btn_ss, btn_lap, btn_rev};
      btn_q <= btn_r;
    end
  end

  assign btn_edge = btn_r & ~btn_q;
  assign clr_e    = btn_edge[3];
  assign ss_e     = btn_edge[2] & ~btn_edge[3];
  assign lap_e    = btn_edge[1] & ~|btn_edge[3:2];
  assign rev_e    = btn_edge[0] & ~|btn_edge[3:1];

  assign lap_full = (lap_count == NL);

`ifdef STOPWATCH_LAP_OVERWRITE_EN
  assign lap_ok  = 1'b1;
  assign wr_next = (wr_ptr == LAST) ? 3'd0 : wr_ptr + 3'd1;
  assign oldest  = lap_full ? wr_ptr : 3'd0;
`else
  assign lap_ok  = ~lap_full;
  assign wr_next = (wr_ptr == LAST) ? wr_ptr : wr_ptr + 3'd1;
  assign oldest  = 3'd0;
`endif

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next-state and one-cycle control strobes for the lap datapath.
  always_comb begin
    state_d   = state;
    clear_all = 1'b0;
    do_lap    = 1'b0;
    rev_enter = 1'b0;
    rev_step  = 1'b0;
    case (state)
      S_IDLE: begin
        if (ss_e) state_d = S_RUN;
      end
      S_RUN: begin
        if (ss_e)                state_d = S_STOP;
        else if (lap_e && lap_ok) do_lap = 1'b1;
      end
      S_STOP: begin
        if (clr_e) begin
          state_d   = S_IDLE;
          clear_all = 1'b1;
        end else if (ss_e) begin
          state_d = S_RUN;
        end else if (rev_e && (lap_count != 3'd0)) begin
          state_d   = S_REVIEW;
          rev_enter = 1'b1;
        end
      end
      S_REVIEW: begin
        if (clr_e) begin
          state_d   = S_IDLE;
          clear_all = 1'b1;
        end else if (rev_e) begin
          state_d = S_STOP;
        end else if (lap_e) begin
          rev_step = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Time only advances in RUN, so a tick alongside an ss edge counts when
  // leaving RUN and not when entering it.
  assign cnt_en = tick_cs & (state == S_RUN);

  sw_time_counter #(
    .CS_MAX  (CS_MAX),
    .SEC_MAX (SEC_MAX),
    .MIN_MAX (MIN_MAX)
  ) u_time (
    .clk  (CLK),
    .rst  (RST),
    .en   (cnt_en),
    .clr  (clear_all),
    .cs   (live.cs),
    .sec  (live.sec),
    .min  (live.min),
    .wrap (wrap)
  );

  // Lap buffer, write/read pointers and valid count. A captured lap takes
  // the counter value before this cycle's tick lands.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      lap_count <= '0;
      for (int i = 0; i < N_LAPS; i++) laps[i] <= '0;
    end else if (clear_all) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      lap_count <= '0;
      for (int i = 0; i < N_LAPS; i++) laps[i] <= '0;
    end else begin
      if (do_lap) begin
        laps[wr_ptr] <= live;
        wr_ptr       <= wr_next;
        if (!lap_full) lap_count <= lap_count + 3'd1;
      end
      if (rev_enter) rd_ptr <= oldest;
      if (rev_step)  rd_ptr <= ((rd_ptr + 3'd1) == lap_count) ? 3'd0 : rd_ptr + 3'd1;
    end
  end

  // Display select and status outputs, combinational from registers.
  always_comb begin
    running   = (state == S_RUN);
    shown     = (state == S_REVIEW) ? laps[rd_ptr] : live;
    disp_min  = shown.min;
    disp_sec  = shown.sec;
    disp_cs   = shown.cs;
    disp_slot = (state == S_REVIEW) ? rd_ptr : 3'd0;
    state_dbg = state;
    slot_led  = '0;
    for (int i = 0; i < 6; i++) begin
      slot_led[i] = (i < N_LAPS) && (3'(i) < lap_count);
    end
  end

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench for stopwatch_controller. Short second/minute terminal
// counts keep the full-rollover case within a few hundred ticks.
module tb_stopwatch_controller;

  localparam logic [3:0] B_CLR = 4'b1000;
  localparam logic [3:0] B_SS  = 4'b0100;
  localparam logic [3:0] B_LAP = 4'b0010;
  localparam logic [3:0] B_REV = 4'b0001;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_STOP = 2'd2, ST_REV = 2'd3;
  localparam int NV = 25;

  logic       CLK, RST, tick_cs;
  logic       btn_ss, btn_lap, btn_clr, btn_rev;
  logic       running, wrap;
  logic [6:0] disp_min, disp_sec, disp_cs;
  logic [2:0] disp_slot, lap_count;
  logic [5:0] slot_led;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int wrap_cnt = 0;

  typedef struct {
    logic [3:0] btn;
    bit         tk;
    int         nt;
    logic [1:0] st;
    logic       run;
    logic [6:0] mn, sc, cs;
    logic [2:0] slot, cnt;
    logic [5:0] led;
  } vec_t;

  vec_t v [NV];
  logic [2:0] exp_q[$];

  stopwatch_controller #(
    .N_LAPS (5), .CS_MAX (99), .SEC_MAX (2), .MIN_MAX (1)
  ) dut (
    .CLK (CLK), .RST (RST), .tick_cs (tick_cs),
    .btn_ss (btn_ss), .btn_lap (btn_lap), .btn_clr (btn_clr), .btn_rev (btn_rev),
    .running (running), .disp_min (disp_min), .disp_sec (disp_sec), .disp_cs (disp_cs),
    .disp_slot (disp_slot), .lap_count (lap_count), .slot_led (slot_led),
    .wrap (wrap), .state_dbg (state_dbg)
  );

  // Clock and wrap-pulse monitor.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(negedge CLK) if (wrap === 1'b1) wrap_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d expected %0d", nm, row, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Hold a button pattern through its edge cycle (optionally with a tick
  // in that same cycle), then release long enough to re-arm edge detection.
  task automatic press(input logic [3:0] b, input bit tk);
    {btn_clr, btn_ss, btn_lap, btn_rev} = b;
    cyc(1);
    tick_cs = tk;
    cyc(1);
    tick_cs = 1'b0;
    {btn_clr, btn_ss, btn_lap, btn_rev} = 4'b0000;
    cyc(2);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_cs = 1'b1;
      cyc(1);
    end
    tick_cs = 1'b0;
  endtask

  task automatic chk_row(input int r);
    chk("state", r, 32'(state_dbg), 32'(v[r].st));
    chk("running", r, 32'(running), 32'(v[r].run));
    chk("disp_min", r, 32'(disp_min), 32'(v[r].mn));
    chk("disp_sec", r, 32'(disp_sec), 32'(v[r].sc));
    chk("disp_cs", r, 32'(disp_cs), 32'(v[r].cs));
    chk("disp_slot", r, 32'(disp_slot), 32'(v[r].slot));
    chk("lap_count", r, 32'(lap_count), 32'(v[r].cnt));
    chk("slot_led", r, 32'(slot_led), 32'(v[r].led));
  endtask

  initial begin
    int w0, start, s;
    RST = 1'b1;
    tick_cs = 1'b0;
    {btn_clr, btn_ss, btn_lap, btn_rev} = 4'b0000;

    //          btn            tk nt   state    run min sec cs  slot cnt led
    v[0]  = '{4'b0000,        0, 0,   ST_IDLE, 0,  0,  0,  0,  0,   0,  6'h00};
    v[1]  = '{B_SS,           1, 0,   ST_RUN,  1,  0,  0,  0,  0,   0,  6'h00};
    v[2]  = '{4'b0000,        0, 150, ST_RUN,  1,  0,  1,  50, 0,   0,  6'h00};
    v[3]  = '{B_SS,           0, 0,   ST_STOP, 0,  0,  1,  50, 0,   0,  6'h00};
    v[4]  = '{4'b0000,        0, 20,  ST_STOP, 0,  0,  1,  50, 0,   0,  6'h00};
    v[5]  = '{B_SS,           1, 0,   ST_RUN,  1,  0,  1,  50, 0,   0,  6'h00};
    v[6]  = '{B_SS,           1, 0,   ST_STOP, 0,  0,  1,  51, 0,   0,  6'h00};
    v[7]  = '{B_REV,          0, 0,   ST_STOP, 0,  0,  1,  51, 0,   0,  6'h00};
    v[8]  = '{B_CLR,          0, 0,   ST_IDLE, 0,  0,  0,  0,  0,   0,  6'h00};
    v[9]  = '{B_SS,           0, 0,   ST_RUN,  1,  0,  0,  0,  0,   0,  6'h00};
    v[10] = '{4'b0000,        0, 42,  ST_RUN,  1,  0,  0,  42, 0,   0,  6'h00};
    v[11] = '{B_LAP,          1, 0,   ST_RUN,  1,  0,  0,  43, 0,   1,  6'h01};
    v[12] = '{B_REV,          0, 0,   ST_RUN,  1,  0,  0,  43, 0,   1,  6'h01};
    v[13] = '{B_CLR,          0, 0,   ST_RUN,  1,  0,  0,  43, 0,   1,  6'h01};
    v[14] = '{B_LAP,          0, 0,   ST_RUN,  1,  0,  0,  43, 0,   2,  6'h03};
    v[15] = '{4'b0000,        0, 100, ST_RUN,  1,  0,  1,  43, 0,   2,  6'h03};
    v[16] = '{B_LAP,          0, 0,   ST_RUN,  1,  0,  1,  43, 0,   3,  6'h07};
    v[17] = '{B_SS,           0, 0,   ST_STOP, 0,  0,  1,  43, 0,   3,  6'h07};
    v[18] = '{B_REV,          0, 0,   ST_REV,  0,  0,  0,  42, 0,   3,  6'h07};
    v[19] = '{B_LAP,          0, 0,   ST_REV,  0,  0,  0,  43, 1,   3,  6'h07};
    v[20] = '{B_LAP,          0, 0,   ST_REV,  0,  0,  1,  43, 2,   3,  6'h07};
    v[21] = '{B_LAP,          0, 0,   ST_REV,  0,  0,  0,  42, 0,   3,  6'h07};
    v[22] = '{B_SS,           0, 0,   ST_REV,  0,  0,  0,  42, 0,   3,  6'h07};
    v[23] = '{B_REV,          0, 0,   ST_STOP, 0,  0,  1,  43, 0,   3,  6'h07};
    v[24] = '{B_CLR|B_SS|B_LAP, 0, 0, ST_IDLE, 0,  0,  0,  0,  0,   0,  6'h00};

    cyc(3);
    chk("reset_wrap", -1, 32'(wrap), 32'd0);
    RST = 1'b0;
    cyc(2);

    for (int r = 0; r < NV; r++) begin
      if (v[r].btn != 4'b0000) press(v[r].btn, v[r].tk);
      if (v[r].nt > 0) ticks(v[r].nt);
      chk_row(r);
    end

    // Full rollover: 01:02.98 plus two ticks wraps to 00:00.00 while running.
    press(B_SS, 1'b0);
    ticks(598);
    chk("pre_wrap_min", 100, 32'(disp_min), 32'd1);
    chk("pre_wrap_sec", 100, 32'(disp_sec), 32'd2);
    chk("pre_wrap_cs", 100, 32'(disp_cs), 32'd98);
    w0 = wrap_cnt;
    ticks(2);
    chk("wrap_min", 101, 32'(disp_min), 32'd0);
    chk("wrap_sec", 101, 32'(disp_sec), 32'd0);
    chk("wrap_cs", 101, 32'(disp_cs), 32'd0);
    chk("wrap_running", 101, 32'(running), 32'd1);
    cyc(3);
    chk("wrap_pulses", 102, 32'(wrap_cnt - w0), 32'd1);

    // Six laps into five slots, then walk the review cursor.
    press(B_SS, 1'b0);
    press(B_CLR, 1'b0);
    press(B_SS, 1'b0);
    for (int i = 0; i < 6; i++) begin
      ticks(10);
      press(B_LAP, 1'b0);
    end
    chk("full_count", 110, 32'(lap_count), 32'd5);
    chk("full_led", 110, 32'(slot_led), 32'h1f);
    press(B_SS, 1'b0);
    press(B_REV, 1'b0);
    chk("review_state", 111, 32'(state_dbg), 32'(ST_REV));
`ifdef STOPWATCH_LAP_OVERWRITE_EN
    start = 1;
`else
    start = 0;
`endif
    for (int k = 0; k < 6; k++) exp_q.push_back(3'((start + k) % 5));
    for (int k = 0; k < 6; k++) begin
      s = int'(exp_q.pop_front());
      chk("review_slot", 120 + k, 32'(disp_slot), 32'(s));
`ifdef STOPWATCH_LAP_OVERWRITE_EN
      chk("review_cs", 120 + k, 32'(disp_cs), (s == 0) ? 32'd60 : 32'((s + 1) * 10));
`else
      chk("review_cs", 120 + k, 32'(disp_cs), 32'((s + 1) * 10));
`endif
      chk("review_sec", 120 + k, 32'(disp_sec), 32'd0);
      if (k < 5) press(B_LAP, 1'b0);
    end

    // Asynchronous reset mid-RUN with a lap edge pending.
    press(B_REV, 1'b0);
    press(B_SS, 1'b0);
    ticks(5);
    btn_lap = 1'b1;
    cyc(1);
    #3;
    RST = 1'b1;
    #1;
    chk("rst_state", 130, 32'(state_dbg), 32'(ST_IDLE));
    chk("rst_running", 130, 32'(running), 32'd0);
    chk("rst_cs", 130, 32'(disp_cs), 32'd0);
    chk("rst_sec", 130, 32'(disp_sec), 32'd0);
    chk("rst_count", 130, 32'(lap_count), 32'd0);
    chk("rst_led", 130, 32'(slot_led), 32'd0);
    btn_lap = 1'b0;
    cyc(2);
    RST = 1'b0;
    cyc(3);
    chk("post_rst_count", 131, 32'(lap_count), 32'd0);
    chk("post_rst_state", 131, 32'(state_dbg), 32'(ST_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
